// File: rtl/stream_fifo_pkg.sv
// Shared constants for stream_fifo and the FIR/matmul wrappers that size
// their pointer and count buses from it.
package stream_fifo_pkg;

    localparam int SF_DATA_WIDTH = 32;
    localparam int SF_ADDR_WIDTH = 3;
    localparam int SF_PTR_WIDTH  = SF_ADDR_WIDTH + 1;
    localparam int SF_CNT_WIDTH  = SF_ADDR_WIDTH + 1;

    function automatic int sf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Handshake events of one cycle.
    typedef struct packed {
        logic wr;
        logic rd;
    } sf_fire_t;

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready stream pair seen by the FIFO: the write side (in_*) and the
// read side (out_*). The FIFO takes the slave modport.
interface stream_fifo_if #(
    parameter int DATA_WIDTH = stream_fifo_pkg::SF_DATA_WIDTH
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo: one synchronous write port, one
// asynchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides,
// occupancy count, almost flags, flush. STREAM_FIFO_WATERMARK_EN adds max_level.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SF_DATA_WIDTH,
    parameter int ADDR_WIDTH = SF_ADDR_WIDTH,
    parameter int AF_THRESH  = sf_depth(ADDR_WIDTH) - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    stream_fifo_if.slave        s,
    output logic [ADDR_WIDTH:0] count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_WIDTH:0] max_level
);
    localparam int          DEPTH = sf_depth(ADDR_WIDTH);
    localparam int          CW    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_THRESH);

    logic [ADDR_WIDTH:0]   wptr, rptr, cnt_nxt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty, full;
    sf_fire_t              fire;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    // out_ready feeds in_ready combinationally so a full FIFO can take a
    // write in the same cycle its head is consumed.
    assign s.in_ready  = ~full | s.out_ready;
    assign s.out_valid = ~empty;
    assign s.out_data  = empty ? '0 : rd_data;

    assign fire.wr = s.in_valid & s.in_ready;
    assign fire.rd = s.out_valid & s.out_ready;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (fire.wr & ~flush & rst_n),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (s.in_data),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (rd_data)
    );

    always_comb begin
        cnt_nxt = count;
        if (flush)                  cnt_nxt = '0;
        else if (fire.wr && !fire.rd) cnt_nxt = count + 1'b1;
        else if (!fire.wr && fire.rd) cnt_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (fire.wr) wptr <= wptr + 1'b1;
            if (fire.rd) rptr <= rptr + 1'b1;
            count <= cnt_nxt;
        end
    end

    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

`ifdef STREAM_FIFO_WATERMARK_EN
    logic [ADDR_WIDTH:0] max_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush)     max_q <= '0;
        else if (cnt_nxt > max_q) max_q <= cnt_nxt;
    end

    assign max_level = max_q;
`else
    assign max_level = '0;
`endif

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
    a_cnt_ptr:   assert property (@(posedge clk) disable iff (!rst_n) count == CW'(wptr - rptr));
endmodule

// File: tb/tb_stream_fifo.sv
// Randomised and directed stimulus for stream_fifo, checked every cycle
// against a queue-based reference model of the FIFO contract.
module tb_stream_fifo;
    import stream_fifo_pkg::*;

    localparam int AW    = SF_ADDR_WIDTH;
    localparam int DW    = SF_DATA_WIDTH;
    localparam int DEPTH = sf_depth(AW);
    localparam int AF_T  = DEPTH - 1;
    localparam int AE_T  = 1;
`ifdef STREAM_FIFO_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, flush;
    logic [AW:0]   count, max_level;
    logic          almost_full, almost_empty;

    stream_fifo_if #(.DATA_WIDTH(DW)) bus();

    stream_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .s            (bus),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .max_level    (max_level)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [DW-1:0] q[$];
    int          mx = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit r,
                         input bit f = 1'b0, input bit rn = 1'b1);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        flush         = f;
        rst_n         = rn;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit            exp_ir, exp_ov, wr, rd;
        logic [DW-1:0] exp_od;
        @(negedge clk);
        exp_ir = (q.size() < DEPTH) || (bus.out_ready === 1'b1);
        exp_ov = (q.size() > 0);
        exp_od = exp_ov ? q[0] : '0;
        check("in_ready",     64'(bus.in_ready),  64'(exp_ir));
        check("out_valid",    64'(bus.out_valid), 64'(exp_ov));
        check("out_data",     64'(bus.out_data),  64'(exp_od));
        check("count",        64'(count),         64'(q.size()));
        check("almost_full",  64'(almost_full),   64'(q.size() >= AF_T));
        check("almost_empty", 64'(almost_empty),  64'(q.size() <= AE_T));
        check("max_level",    64'(max_level),     WM ? 64'(mx) : 64'd0);
        wr = (bus.in_valid === 1'b1) && exp_ir;
        rd = exp_ov && (bus.out_ready === 1'b1);
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
            mx = 0;
        end else begin
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(bus.in_data);
            if (q.size() > mx) mx = q.size();
        end
        #1;
    endtask

    initial begin
        drive(0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        q.delete();
        mx = 0;
        repeat (2) cycle();
        drive(0, '0, 0);
        repeat (2) cycle();
        check("rst_in_ready",     64'(bus.in_ready),  64'd1);
        check("rst_out_valid",    64'(bus.out_valid), 64'd0);
        check("rst_out_data",     64'(bus.out_data),  64'd0);
        check("rst_count",        64'(count),         64'd0);
        check("rst_almost_empty", 64'(almost_empty),  64'd1);
        check("rst_almost_full",  64'(almost_full),   64'd0);
        check("rst_max_level",    64'(max_level),     64'd0);

        // Fill to full with the consumer stalled, then one refused write.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, DW'(i), 0);
            cycle();
            if (i == DEPTH - 1) check("af_at_7", 64'(almost_full), 64'd1);
        end
        check("full_count",    64'(count),        64'(DEPTH));
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_head",     64'(bus.out_data), 64'd1);
        drive(1, DW'(DEPTH + 1), 0);
        cycle();

        // Stream through a full FIFO across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            drive(1, DW'(DEPTH + 1 + i), 1);
            cycle();
            check("wrap_count", 64'(count), 64'(DEPTH));
            check("wrap_head",  64'(bus.out_data), 64'(i + 2));
        end
        drive(0, '0, 1);
        repeat (DEPTH + 1) cycle();

        // Simultaneous write/read on empty: no bypass.
        drive(1, DW'('hA5), 1);
        cycle();
        drive(0, '0, 0);
        check("byp_out_valid", 64'(bus.out_valid), 64'd1);
        check("byp_out_data",  64'(bus.out_data),  64'hA5);
        check("byp_count",     64'(count),         64'd1);
        cycle();
        drive(0, '0, 1);
        cycle();

        // Flush with a concurrent write.
        drive(0, '0, 0, 1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, DW'('h50 + i), 0);
            cycle();
        end
        check("pre_flush_max", 64'(max_level), WM ? 64'd5 : 64'd0);
        drive(1, DW'('hEE), 0, 1);
        cycle();
        drive(0, '0, 0);
        check("flush_count",     64'(count),         64'd0);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_out_data",  64'(bus.out_data),  64'd0);
        check("flush_max",       64'(max_level),     64'd0);
        cycle();

        // Reset dominating flush and a write.
        for (int i = 0; i < 4; i++) begin
            drive(1, DW'('h70 + i), 0);
            cycle();
        end
        drive(1, DW'('h77), 0, 1, 0);
        cycle();
        drive(0, '0, 1);
        check("mrst_count",     64'(count),         64'd0);
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        cycle();

        // Random traffic, biased first toward filling, then draining.
        for (int i = 0; i < 600; i++) begin
            bit v, r, f, rn;
            v  = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            r  = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 49) == 0);
            rn = ($urandom_range(0, 119) != 0);
            drive(v, DW'($urandom), r, f, rn);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
Synchronous single-clock FIFO with valid/ready streaming handshake on both sides. It is the parametrised successor of the basic pointer FIFO used between Caravel user-project stages (WB/AXI-Stream bridges, FIR and matmul engines). It adds the following over the basic FIFO:
- occupancy count
- programmable almost-full/almost-empty flags
- synchronous flush
- optional high-water-mark tracking

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH entries (ADDR_WIDTH >= 1).
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (range 1..DEPTH).
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (range 0..DEPTH-1).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, reset; synchronous, active-low. Sampled only on a clk rising edge.
- flush, input, 1, synchronous clear of contents.
- in_valid, input, 1, write request.
- in_data, input, DATA_WIDTH, write payload.
- in_ready, output, 1, FIFO can accept this cycle.
- out_valid, output, 1, head entry available.
- out_data, output, DATA_WIDTH, head entry payload.
- out_ready, input, 1, consumer takes head this cycle.
- count, output, ADDR_WIDTH+1, current occupancy, 0..DEPTH.
- almost_full, output, 1, count >= AF_THRESH.
- almost_empty, output, 1, count <= AE_THRESH.
- max_level, output, ADDR_WIDTH+1, high-water mark (optional feature; otherwise 0).

Behaviour:
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = (wptr == rptr).
  - full = MSBs differ and the low bits are equal.
  - Pointers wrap naturally modulo 2**(ADDR_WIDTH+1).
- Handshakes:
  - Write fires = in_valid & in_ready.
  - Read fires = out_valid & out_ready.
  - Payload must be held stable while valid is high and ready is low; a violation is the source's error, and the FIFO samples in_data only when a write fires.
- Output ready/valid:
  - in_ready = ~full | out_ready. A simultaneous write is accepted when full and a read fires; this is a combinational out_ready->in_ready path and is documented as such.
  - out_valid = ~empty. out_data = mem[rptr low bits], combinational (first-word fall-through, zero read latency).
  - out_data = 0 when empty, so benches can compare deterministically.
- Write latency: an entry written at edge N is visible on out_data/out_valid after edge N (the next cycle).
- count: registered. +1 on write only, -1 on read only, unchanged on both or neither. It must always equal wptr - rptr. almost_full and almost_empty are derived combinationally from count.
- Simultaneous write and read:
  - When empty: the write is accepted and the read cannot fire (out_valid = 0). No bypass; data appears next cycle.
  - When full: both fire, count stays DEPTH, and the write lands in the slot freed by the read.
- flush (rst_n high):
  - At the edge: wptr = rptr = 0 and count = 0.
  - Any write or read firing in the same cycle is discarded.
  - in_ready is still computed normally that cycle; the upstream handshake is considered consumed but the data is dropped.
  - Memory contents are not cleared.
- Reset (rst_n low at edge, dominates flush):
  - Pointers and count go to 0; max_level goes to 0.
  - Memory is not reset.
  - Post-reset outputs: in_ready = 1, out_valid = 0, out_data = 0, count = 0, almost_empty = 1, almost_full = 0.
  - Reset mid-stream drops all contents immediately at that edge.
- Overflow and underflow cannot occur by construction; assertions check that count never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro STREAM_FIFO_WATERMARK_EN.
- Defined:
  - max_level is a register updated each edge to max(max_level, next count).
  - Cleared by reset and by flush.
  - Read-only to the system (exported to a CSR by the parent).
- Undefined: max_level is tied to 0, no register is inferred, and the port remains present so parent wiring is unchanged.

Decomposition:
- Package stream_fifo_pkg holds:
  - the default DATA_WIDTH/ADDR_WIDTH constants;
  - the localparam function computing DEPTH;
  - pointer/count width constants shared with the FIR/matmul wrappers.
- One sub-module, fifo_mem: register array with one synchronous write port and one asynchronous read port, with no reset. stream_fifo keeps the pointers, count, flags, flush and watermark.

Test Plan:
- Reset, then idle → in_ready=1, out_valid=0, count=0, almost_empty=1, almost_full=0, max_level=0.
- DATA_WIDTH=32, ADDR_WIDTH=3, out_ready=0, write 0x1..0x8 → in_ready=0 after the 8th write, count=8, almost_full=1 from count=7, out_data=0x1.
- From full, hold in_valid=1 and out_ready=1 for 20 cycles with incrementing data → count stays 8, output order strictly sequential 0x1,0x2,… across pointer wrap.
- Empty FIFO, in_valid=1 and out_ready=1 same cycle with 0xA5 → no read that cycle; next cycle out_valid=1, out_data=0xA5, count=1.
- Fill to 5, assert flush with in_valid=1 → next cycle count=0, out_valid=0, out_data=0, and the flushed write is absent. With STREAM_FIFO_WATERMARK_EN, max_level is 5 before flush and 0 after.
- Fill to 4, pulse rst_n=0 for one edge while flush=1 and in_valid=1 → count=0, out_valid=0 after that edge; no entries survive.
